// File: rtl/turn_sequencer_if.sv
// Board-write and win-check handshake between the turn sequencer (master)
// and the memory / winCheck datapath (slave).
interface turn_sequencer_if #(
  parameter int COLW = 3,
  parameter int ROWW = 3
);
  logic            wr_req;
  logic            wr_ack;
  logic [COLW-1:0] wr_col;
  logic [ROWW-1:0] wr_row;
  logic            wr_player;
  logic            chk_start;
  logic            chk_done;
  logic            chk_win;

  modport master (
    output wr_req, wr_col, wr_row, wr_player, chk_start,
    input  wr_ack, chk_done, chk_win
  );

  modport slave (
    input  wr_req, wr_col, wr_row, wr_player, chk_start,
    output wr_ack, chk_done, chk_win
  );
endinterface

// File: rtl/turn_sequencer.sv
// Connect4 turn controller: one coin per accepted Enter, written to board memory,
// then win-checked; alternates players and declares win or draw.
module turn_sequencer #(
  parameter int NCOLS = 8,
  parameter int NROWS = 6,
  parameter int COLW  = 3,
  parameter int ROWW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enter,
  input  logic            new_game,
  input  logic [COLW-1:0] colval,
  turn_sequencer_if.master bus,
  output logic            fsm_rst,
  output logic            player,
  output logic            busy,
  output logic            col_full,
  output logic            game_over,
  output logic [1:0]      winner
);

  localparam int CELLS = NCOLS * NROWS;
  localparam int MCW   = $clog2(CELLS + 1);
  localparam logic [MCW-1:0]  CELLS_L = MCW'(CELLS);
  localparam logic [ROWW-1:0] ROWS_L  = ROWW'(NROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_CHECK, S_WAIT, S_NEXT, S_OVER
  } state_t;

  state_t state, state_nxt;

  logic [NCOLS-1:0][ROWW-1:0] height;
  logic [MCW-1:0]             moves;
  logic [COLW-1:0]            wcol;
  logic [ROWW-1:0]            wrow;
  logic                       wply;
  logic [ROWW-1:0]            sel_h;
  logic                       in_range;
  logic                       accept, reject, commit, clear, end_win, end_draw;

  assign in_range = int'(colval) < NCOLS;
  assign sel_h    = height[colval];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    commit    = 1'b0;
    clear     = 1'b0;
    end_win   = 1'b0;
    end_draw  = 1'b0;
    case (state)
      S_IDLE: if (enter) begin
        if (in_range && sel_h < ROWS_L) begin
          accept    = 1'b1;
          state_nxt = S_WRITE;
        end else begin
          reject    = 1'b1;
        end
      end
      S_WRITE: if (bus.wr_ack) begin
        commit    = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = S_WAIT;
      // move count was already bumped on the write ack, so it is final here
      S_WAIT: if (bus.chk_done) begin
        if (bus.chk_win) begin
          end_win   = 1'b1;
          state_nxt = S_OVER;
        end else if (moves == CELLS_L) begin
          end_draw  = 1'b1;
          state_nxt = S_OVER;
        end else begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: state_nxt = S_IDLE;
      S_OVER: if (new_game) begin
        clear     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      height <= '0;
    end else begin
      for (int c = 0; c < NCOLS; c++) begin
        if (clear)
          height[c] <= '0;
        else if (commit && wcol == COLW'(c) && height[c] < ROWS_L)
          height[c] <= height[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      moves    <= '0;
      player   <= 1'b0;
      winner   <= 2'd0;
      wcol     <= '0;
      wrow     <= '0;
      wply     <= 1'b0;
      col_full <= 1'b0;
    end else begin
      col_full <= reject;
      if (accept) begin
        wcol <= colval;
        wrow <= sel_h;
        wply <= player;
      end
      if (commit)         moves  <= moves + 1'b1;
      if (state == S_NEXT) player <= ~player;
      if (end_win)        winner <= wply ? 2'd2 : 2'd1;
      if (end_draw)       winner <= 2'd3;
      if (clear) begin
        moves  <= '0;
        player <= 1'b0;
        winner <= 2'd0;
      end
    end
  end

  // Pulses decode straight from state, so an async reset kills them at once.
  assign bus.wr_req    = (state == S_WRITE);
  assign bus.chk_start = (state == S_CHECK);
  assign bus.wr_col    = wcol;
  assign bus.wr_row    = wrow;
  assign bus.wr_player = wply;
  assign fsm_rst       = (state == S_NEXT);
  assign game_over     = (state == S_OVER);
  assign busy          = (state != S_IDLE) && (state != S_OVER);

endmodule
